// File: rtl/param_cache_if.sv
// Core-side request/ack bus and backing-memory handshake of param_cache,
// bundled as one interface: slave = the cache, master = core plus memory.
interface param_cache_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    // Core load/store side
    logic              req;
    logic              WE;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dataIn;
    logic [DATA_W-1:0] dataOut;
    logic              ack;
    logic              busy;
    logic              hit;

    // Backing data memory side
    logic              memReq;
    logic              memWE;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memDataOut;
    logic [DATA_W-1:0] memDataIn;
    logic              memAck;

    modport slave (
        input  req, WE, addr, dataIn, memDataIn, memAck,
        output dataOut, ack, busy, hit, memReq, memWE, memAddr, memDataOut
    );

    modport master (
        output req, WE, addr, dataIn, memDataIn, memAck,
        input  dataOut, ack, busy, hit, memReq, memWE, memAddr, memDataOut
    );
endinterface

// File: rtl/param_cache.sv
// Direct-mapped, write-through, no-write-allocate cache, one word per line.
// Define PARAM_CACHE_STATS_EN to add saturating hitCount/missCount outputs.
module param_cache #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int INDEX_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    param_cache_if.slave  bus
`ifdef PARAM_CACHE_STATS_EN
    ,
    output logic [15:0]   hitCount,
    output logic [15:0]   missCount
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        MEM_RD,
        MEM_WR
    } state_t;

    state_t              state_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [LINES];

    logic                ack_q;
    logic                hit_q;
    logic                wr_hit_q;
    logic                memReq_q;
    logic                memWE_q;
    logic [DATA_W-1:0]   dataOut_q;
    logic [ADDR_W-1:0]   memAddr_q;
    logic [DATA_W-1:0]   memDataOut_q;

    // Lookup uses the live request address; a fill uses the captured miss address.
    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                lookup_hit;

    assign req_idx    = bus.addr[INDEX_W-1:0];
    assign req_tag    = bus.addr[ADDR_W-1:INDEX_W];
    assign fill_idx   = memAddr_q[INDEX_W-1:0];
    assign fill_tag   = memAddr_q[ADDR_W-1:INDEX_W];
    assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    logic                line_we_d;
    logic                tag_we_d;
    logic [INDEX_W-1:0]  line_idx_d;
    logic [DATA_W-1:0]   line_data_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        line_we_d   = 1'b0;
        tag_we_d    = 1'b0;
        line_idx_d  = req_idx;
        line_data_d = bus.dataIn;
        if (!rst) begin
            if (state_q == MEM_RD && bus.memAck) begin
                line_we_d   = 1'b1;
                tag_we_d    = 1'b1;
                line_idx_d  = fill_idx;
                line_data_d = bus.memDataIn;
            end else if (state_q == IDLE && bus.req && bus.WE && lookup_hit) begin
                line_we_d   = 1'b1;
            end
        end
    end

    // NOTE: data/tag arrays carry no reset; the flopped valid bits mask stale contents.
    always_ff @(posedge clk) begin
        if (line_we_d) data_mem[line_idx_d] <= line_data_d;
        if (tag_we_d)  tag_mem[line_idx_d]  <= fill_tag;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            ack_q        <= 1'b0;
            hit_q        <= 1'b0;
            wr_hit_q     <= 1'b0;
            memReq_q     <= 1'b0;
            memWE_q      <= 1'b0;
            dataOut_q    <= '0;
            memAddr_q    <= '0;
            memDataOut_q <= '0;
        end else begin
            ack_q <= 1'b0;
            hit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        if (bus.WE) begin
                            state_q      <= MEM_WR;
                            memReq_q     <= 1'b1;
                            memWE_q      <= 1'b1;
                            memAddr_q    <= bus.addr;
                            memDataOut_q <= bus.dataIn;
                            wr_hit_q     <= lookup_hit;
                        end else if (lookup_hit) begin
                            dataOut_q    <= data_mem[req_idx];
                            ack_q        <= 1'b1;
                            hit_q        <= 1'b1;
                        end else begin
                            state_q      <= MEM_RD;
                            memReq_q     <= 1'b1;
                            memWE_q      <= 1'b0;
                            memAddr_q    <= bus.addr;
                        end
                    end
                end
                MEM_RD: begin
                    if (bus.memAck) begin
                        valid_q[fill_idx] <= 1'b1;
                        dataOut_q         <= bus.memDataIn;
                        ack_q             <= 1'b1;
                        memReq_q          <= 1'b0;
                        state_q           <= IDLE;
                    end
                end
                MEM_WR: begin
                    if (bus.memAck) begin
                        ack_q    <= 1'b1;
                        hit_q    <= wr_hit_q;
                        memReq_q <= 1'b0;
                        memWE_q  <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack        = ack_q;
    assign bus.hit        = hit_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.dataOut    = dataOut_q;
    assign bus.memReq     = memReq_q;
    assign bus.memWE      = memWE_q;
    assign bus.memAddr    = memAddr_q;
    assign bus.memDataOut = memDataOut_q;

`ifdef PARAM_CACHE_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;

    // Counted in the ack cycle, so the new value is visible one cycle after ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (ack_q) begin
            if (hit_q) begin
                if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
            end else begin
                if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end

    assign hitCount  = hit_count_q;
    assign missCount = miss_count_q;
`endif

endmodule

// File: tb/tb_param_cache.sv
// Self-checking bench for param_cache: scoreboard of expected acks plus a
// behavioural backing memory with programmable memAck delay.
module tb_param_cache;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    param_cache_if #(.DATA_W(16), .ADDR_W(16)) bus ();

`ifdef PARAM_CACHE_STATS_EN
    logic [15:0] hitCount;
    logic [15:0] missCount;
`endif

    param_cache #(.DATA_W(16), .ADDR_W(16), .INDEX_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef PARAM_CACHE_STATS_EN
        ,
        .hitCount  (hitCount),
        .missCount (missCount)
`endif
    );

    typedef struct {
        logic [15:0] data;
        logic        hit;
        int          lat;
        int          issue;
    } exp_t;

    exp_t        sb_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cycle        = 0;
    logic [15:0] exp_dout     = 16'h0000;

    // Backing memory model state
    logic [15:0] mem_model [0:65535];
    int          mem_delay      = 0;
    int          mem_cnt        = 0;
    int          mem_acks       = 0;
    int          mem_req_cycles = 0;
    logic        last_mem_we    = 1'b0;
    logic [15:0] last_mem_addr  = 16'h0;
    logic [15:0] last_mem_data  = 16'h0;
    logic [15:0] held_addr      = 16'h0;
    logic        addr_moved     = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    // Memory responder: acks after mem_delay cycles of memReq, for one cycle.
    initial begin
        bus.memAck    = 1'b0;
        bus.memDataIn = 16'h0;
        forever begin
            @(negedge clk);
            if (bus.memAck) begin
                bus.memAck = 1'b0;
                mem_cnt    = 0;
            end else if (bus.memReq) begin
                mem_req_cycles++;
                if (mem_cnt == 0) held_addr = bus.memAddr;
                else if (bus.memAddr !== held_addr) addr_moved = 1'b1;
                if (mem_cnt >= mem_delay) begin
                    bus.memAck    = 1'b1;
                    last_mem_we   = bus.memWE;
                    last_mem_addr = bus.memAddr;
                    last_mem_data = bus.memDataOut;
                    if (bus.memWE) mem_model[bus.memAddr] = bus.memDataOut;
                    else           bus.memDataIn = mem_model[bus.memAddr];
                    mem_acks++;
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: every ack must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.ack === 1'b1) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_ack: got ack=1 at cycle %0d, required no ack", cycle);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (bus.dataOut !== e.data) begin
                        tests_failed++;
                        $display("FAIL dataOut: got %h required %h", bus.dataOut, e.data);
                    end
                    tests_run++;
                    if (bus.hit !== e.hit) begin
                        tests_failed++;
                        $display("FAIL hit: got %b required %b", bus.hit, e.hit);
                    end
                    if (e.lat >= 0) begin
                        tests_run++;
                        if (cycle - e.issue != e.lat) begin
                            tests_failed++;
                            $display("FAIL latency: got %0d required %0d", cycle - e.issue, e.lat);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [15:0] data, input logic hit, input int lat);
        exp_t e;
        e.data  = data;
        e.hit   = hit;
        e.lat   = lat;
        e.issue = cycle;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_timeout: got %0d pending acks, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        exp_dout = 16'h0000;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] d, input logic h, input int lat);
        int req0;
        int acks0;
        req0       = mem_req_cycles;
        acks0      = mem_acks;
        addr_moved = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.WE = 1'b0; bus.addr = a; bus.dataIn = 16'h0;
        push_exp(d, h, lat);
        exp_dout = d;
        @(negedge clk);
        bus.req = 1'b0;
        wait_done("read");
        tests_run++;
        if (h) begin
            if (mem_req_cycles != req0) begin
                tests_failed++;
                $display("FAIL hit_no_memreq: got %0d memReq cycles required 0", mem_req_cycles - req0);
            end
        end else if (mem_acks != acks0 + 1 || last_mem_we !== 1'b0 || last_mem_addr !== a || addr_moved) begin
            tests_failed++;
            $display("FAIL miss_fetch: got we=%b addr=%h moved=%b required we=0 addr=%h moved=0",
                     last_mem_we, last_mem_addr, addr_moved, a);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic h);
        int acks0;
        acks0      = mem_acks;
        addr_moved = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.WE = 1'b1; bus.addr = a; bus.dataIn = d;
        push_exp(exp_dout, h, -1);
        @(negedge clk);
        bus.req = 1'b0; bus.WE = 1'b0;
        wait_done("write");
        tests_run++;
        if (mem_acks != acks0 + 1 || last_mem_we !== 1'b1 || last_mem_addr !== a ||
            last_mem_data !== d || addr_moved) begin
            tests_failed++;
            $display("FAIL write_through: got we=%b addr=%h data=%h required we=1 addr=%h data=%h",
                     last_mem_we, last_mem_addr, last_mem_data, a, d);
        end
    endtask

    task automatic test_reset();
        logic [15:0] got;
        do_reset();
        tests_run++;
        got = {11'b0, bus.ack, bus.hit, bus.busy, bus.memReq, bus.memWE};
        if (got !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got ack/hit/busy/memReq/memWE=%b required 00000", got[4:0]);
        end
        tests_run++;
        if (bus.dataOut !== 16'h0 || bus.memAddr !== 16'h0 || bus.memDataOut !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got dataOut=%h memAddr=%h memDataOut=%h required 0",
                     bus.dataOut, bus.memAddr, bus.memDataOut);
        end
    endtask

    task automatic test_read_miss_hit();
        mem_delay = 3;
        do_read(16'h0001, 16'hBBBB, 1'b0, 5);
        do_read(16'h0001, 16'hBBBB, 1'b1, 1);
    endtask

    task automatic test_write_miss();
        do_write(16'h0000, 16'hAAAA, 1'b0);
        do_read(16'h0000, 16'hAAAA, 1'b0, 5);
        do_read(16'h0000, 16'hAAAA, 1'b1, 1);
    endtask

    task automatic test_alias();
        do_read(16'h8000, 16'hCCCC, 1'b0, -1);
        do_read(16'h0000, 16'hAAAA, 1'b0, -1);
    endtask

    task automatic test_write_hit();
        do_write(16'h0001, 16'h1234, 1'b1);
        do_read(16'h0001, 16'h1234, 1'b1, 1);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.req = 1'b1; bus.WE = 1'b0; bus.addr = 16'h0001;
        push_exp(16'h1234, 1'b1, 1);
        @(negedge clk);
        bus.addr = 16'h0000;
        push_exp(16'hAAAA, 1'b1, 1);
        @(negedge clk);
        bus.req  = 1'b0;
        exp_dout = 16'hAAAA;
        wait_done("b2b");
        mem_delay = 0;
        do_read(16'h0002, 16'h2222, 1'b0, 2);
    endtask

    task automatic test_reset_abandon();
        int acks0;
        mem_delay = 50;
        acks0     = mem_acks;
        @(negedge clk);
        bus.req = 1'b1; bus.WE = 1'b0; bus.addr = 16'h0005;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.memReq !== 1'b1 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abandon_pending: got memReq=%b busy=%b required 1 1", bus.memReq, bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.memReq !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL abandon_drop: got memReq=%b busy=%b ack=%b required 0 0 0",
                     bus.memReq, bus.busy, bus.ack);
        end
        rst      = 1'b0;
        exp_dout = 16'h0000;
        repeat (10) @(negedge clk);
        tests_run++;
        if (mem_acks != acks0) begin
            tests_failed++;
            $display("FAIL abandon_memack: got %0d memAcks required 0", mem_acks - acks0);
        end
        mem_delay = 1;
        do_read(16'h0005, 16'h5555, 1'b0, 3);
    endtask

`ifdef PARAM_CACHE_STATS_EN
    task automatic test_stats();
        do_reset();
        mem_delay = 1;
        do_read(16'h0003, 16'h3333, 1'b0, -1);
        do_read(16'h0003, 16'h3333, 1'b1, 1);
        do_read(16'h0003, 16'h3333, 1'b1, 1);
        @(negedge clk);
        tests_run++;
        if (missCount !== 16'd1 || hitCount !== 16'd2) begin
            tests_failed++;
            $display("FAIL stats_count: got miss=%0d hit=%0d required 1 2", missCount, hitCount);
        end
        do_reset();
        tests_run++;
        if (missCount !== 16'd0 || hitCount !== 16'd0) begin
            tests_failed++;
            $display("FAIL stats_reset: got miss=%0d hit=%0d required 0 0", missCount, hitCount);
        end
    endtask
`endif

    initial begin
        bus.req    = 1'b0;
        bus.WE     = 1'b0;
        bus.addr   = 16'h0;
        bus.dataIn = 16'h0;
        for (int i = 0; i < 65536; i++) mem_model[i] = 16'(i) ^ 16'h5A5A;
        mem_model[16'h0001] = 16'hBBBB;
        mem_model[16'h0002] = 16'h2222;
        mem_model[16'h0003] = 16'h3333;
        mem_model[16'h0005] = 16'h5555;
        mem_model[16'h8000] = 16'hCCCC;

        test_reset();
        test_read_miss_hit();
        test_write_miss();
        test_alias();
        test_write_hit();
        test_back_to_back();
        test_reset_abandon();
`ifdef PARAM_CACHE_STATS_EN
        test_stats();
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/param_cache.md
Name: param_cache

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate cache for 16-bit-word data memory.
- Successor to the single-cycle cache: adds tag/valid tracking, hit/miss detection, and a handshaked backing-memory port.
- Sits between the core load/store unit (request/ack side) and the data memory (mem side).

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 16, word-address width.
- INDEX_W, 6, index bits; 2**INDEX_W lines of one word each. Legal range 1..ADDR_W-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- WE  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address; sampled with req.
- dataIn  in  DATA_W  write data; sampled with req.
- dataOut  out  DATA_W  read data; valid when ack=1, held until the next read completes.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state != IDLE.
- hit  out  1  valid with ack: 1 = the request hit.
- memReq  out  1  backing-memory request; held until memAck.
- memWE  out  1  backing-memory write enable.
- memAddr  out  ADDR_W  backing-memory address.
- memDataOut  out  DATA_W  backing-memory write data.
- memDataIn  in  DATA_W  backing-memory read data; valid with memAck.
- memAck  in  1  backing-memory completion; sampled only in MEM_RD or MEM_WR.

Behaviour:
- Address split: index = addr[INDEX_W-1:0]; tag = addr[ADDR_W-1:INDEX_W].
- Storage: data array, tag array and valid bits, each 2**INDEX_W entries.
- Valid bits are flops so reset clears all of them in one cycle.
- Reset:
  - state = IDLE; all valid = 0.
  - ack, hit, busy, memReq, memWE = 0; dataOut, memAddr, memDataOut = 0.
  - Reset during MEM_RD or MEM_WR abandons the access: memReq is 0 on the next cycle, no ack, and no line is written.
- States: IDLE, MEM_RD, MEM_WR.
- IDLE, req=1, WE=0, hit (valid[index] and tag match):
  - dataOut <= line data; ack=1 and hit=1 next cycle; stay in IDLE.
  - Read-hit latency is 1 cycle.
- IDLE, req=1, WE=0, miss:
  - Go to MEM_RD; memReq=1, memWE=0, memAddr=addr from the next cycle.
- MEM_RD, memAck=1:
  - Write memDataIn into the line; set tag; valid=1.
  - dataOut <= memDataIn; ack=1, hit=0 next cycle; go to IDLE.
  - memReq falls in the same cycle ack rises.
- IDLE, req=1, WE=1:
  - If hit, update line data in the same edge. A write miss does not allocate.
  - Go to MEM_WR; memReq=1, memWE=1, memAddr=addr, memDataOut=dataIn.
- MEM_WR, memAck=1:
  - ack=1 next cycle; hit = the hit status recorded at acceptance; go to IDLE.
- req while busy=1 is ignored, not queued. The requester waits for ack.
- ack is asserted in the cycle after the accepting or completing edge. A new req may be accepted in that same ack cycle, giving back-to-back hits at 1/cycle.
- memAck arriving in the cycle memReq first rises is legal; minimum miss latency is 2 cycles.
- Aliasing: addresses with equal index and different tag evict each other, e.g. 0x0000 and 0x8000.
- dataOut is unchanged by writes.

Optional Feature:
- Macro: PARAM_CACHE_STATS_EN.
- Defined:
  - Adds outputs hitCount[15:0] and missCount[15:0].
  - Each increments by 1 on every ack with hit=1 or hit=0 respectively, reads and writes both.
  - Counters saturate at 0xFFFF and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then read 0x0001 with memory returning 0xBBBB after a 3-cycle memAck delay -> memReq high with memAddr=0x0001 until memAck; then ack=1, hit=0, dataOut=0xBBBB. Re-read 0x0001 -> ack one cycle after req, hit=1, dataOut=0xBBBB, memReq stays 0.
- Write 0x0000=0xAAAA (miss) -> memWE=1, memDataOut=0xAAAA, ack with hit=0. Then read 0x0000 -> miss (no allocate), memory returns 0xAAAA. Second read -> hit, 0xAAAA.
- Aliasing with INDEX_W=6: fill 0x0000 (0xAAAA), then read 0x8000 (memory returns 0xCCCC) -> miss. Read 0x0000 again -> miss, refetch 0xAAAA.
- Write hit on cached 0x0001 with 0x1234 -> line updated and write-through issued. Read 0x0001 -> hit=1, dataOut=0x1234.
- Assert rst during MEM_RD before memAck -> next cycle memReq=0, busy=0, no ack. Read of the same address afterwards misses.
- With PARAM_CACHE_STATS_EN: the sequence of 1 miss then 2 hits -> missCount=1, hitCount=2. After rst -> both 0.
